// File: rtl/issue_queue_pkg.sv
// Shared types for the rename -> dispatch -> issue-queue path.
// write_req_t is one instruction write into an issue queue; entry_type
// selects which of the four queues receives it.
package issue_queue_pkg;

  localparam int unsigned MACHINE_WIDTH = 2;
  localparam int unsigned WRITE_NUM     = MACHINE_WIDTH;

  localparam int unsigned ROB_W  = 6;
  localparam int unsigned PREG_W = 7;
  localparam int unsigned OP_W   = 8;

  typedef enum logic [1:0] {
    ET_ALU    = 2'd0,
    ET_MEM    = 2'd1,
    ET_BRANCH = 2'd2,
    ET_MULT   = 2'd3
  } entry_type_e;

  typedef struct packed {
    logic              valid;
    entry_type_e       entry_type;
    logic [ROB_W-1:0]  rob_idx;
    logic [PREG_W-1:0] pdst;
    logic [PREG_W-1:0] psrc1;
    logic [PREG_W-1:0] psrc2;
    logic [OP_W-1:0]   opcode;
  } write_req_t;

endpackage

// File: rtl/dispatch_stage.sv
// Dispatch stage between rename and the ALU/MEM/BRANCH/MULT issue queues.
// Holds one renamed bundle and releases it, all-or-nothing, only when every
// queue targeted by the bundle has enough credits.
//
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   flush           synchronous pipeline flush; empties the stage, refills credits
//   in_req          renamed bundle (per-slot valid, entry_type picks the queue)
//   in_ready        stage can take in_req this cycle (combinational from state)
//   out_req         writes to the issue queues (combinational from state + flush)
//   rel_alu/rel_mem entries leaving ALU/MEM queue this cycle (0..2)
//   rel_br/rel_mult entries leaving BRANCH/MULT queue this cycle (0..1)
//   credit_err      sticky credit counter over/underflow flag
module dispatch_stage
  import issue_queue_pkg::*;
#(
  parameter int unsigned ALU_LEN  = 8,
  parameter int unsigned MEM_LEN  = 8,
  parameter int unsigned BR_LEN   = 2,
  parameter int unsigned MULT_LEN = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  write_req_t [WRITE_NUM-1:0]   in_req,
  output logic                         in_ready,
  output write_req_t [WRITE_NUM-1:0]   out_req,
  input  logic [1:0]                   rel_alu,
  input  logic [1:0]                   rel_mem,
  input  logic                         rel_br,
  input  logic                         rel_mult,
  output logic                         credit_err
);

  localparam int unsigned ALU_CW  = $clog2(ALU_LEN) + 1;
  localparam int unsigned MEM_CW  = $clog2(MEM_LEN) + 1;
  localparam int unsigned BR_CW   = $clog2(BR_LEN) + 1;
  localparam int unsigned MULT_CW = $clog2(MULT_LEN) + 1;
  // Common arithmetic width for credit math; wide enough for any LEN + release.
  localparam int unsigned AW      = 8;
  localparam int unsigned NW      = $clog2(WRITE_NUM + 1);

  logic                       buf_valid;
  write_req_t [WRITE_NUM-1:0] buf_req;

  logic [ALU_CW-1:0]  cnt_alu,  cnt_alu_d;
  logic [MEM_CW-1:0]  cnt_mem,  cnt_mem_d;
  logic [BR_CW-1:0]   cnt_br,   cnt_br_d;
  logic [MULT_CW-1:0] cnt_mult, cnt_mult_d;

  logic [NW-1:0] need_alu, need_mem, need_br, need_mult;
  logic          any_in;
  logic          fire;
  logic          accept;
  logic          err_any;

  logic [AW:0] res_alu, res_mem, res_br, res_mult;

  // Returns {err, next}; on over/underflow next holds the current count.
  function automatic logic [AW:0] credit_next(input logic [AW-1:0] cnt,
                                               input logic [AW-1:0] rel,
                                               input logic [AW-1:0] used,
                                               input logic [AW-1:0] len);
    logic [AW-1:0] sum;
    sum = cnt + rel;
    if ((sum < used) || ((sum - used) > len)) begin
      credit_next = {1'b1, cnt};
    end else begin
      credit_next = {1'b0, sum - used};
    end
  endfunction

  // Per-queue demand of the buffered bundle.
  always_comb begin
    need_alu  = '0;
    need_mem  = '0;
    need_br   = '0;
    need_mult = '0;
    for (int i = 0; i < int'(WRITE_NUM); i++) begin
      if (buf_req[i].valid) begin
        case (buf_req[i].entry_type)
          ET_ALU:    need_alu  = need_alu  + NW'(1);
          ET_MEM:    need_mem  = need_mem  + NW'(1);
          ET_BRANCH: need_br   = need_br   + NW'(1);
          ET_MULT:   need_mult = need_mult + NW'(1);
        endcase
      end
    end
  end

  // Fire only on registered credits; same-cycle releases count next cycle.
  always_comb begin
    fire = buf_valid
        && (AW'(need_alu)  <= AW'(cnt_alu))
        && (AW'(need_mem)  <= AW'(cnt_mem))
        && (AW'(need_br)   <= AW'(cnt_br))
        && (AW'(need_mult) <= AW'(cnt_mult));
    in_ready = !buf_valid || fire;
    any_in   = 1'b0;
    for (int i = 0; i < int'(WRITE_NUM); i++) begin
      any_in = any_in | in_req[i].valid;
    end
    accept = any_in && in_ready;
  end

  // Payload passes through; valid is gated by fire and suppressed on flush.
  always_comb begin
    out_req = buf_req;
    for (int i = 0; i < int'(WRITE_NUM); i++) begin
      out_req[i].valid = buf_req[i].valid && fire && !flush;
    end
  end

  // Credit update: release and dispatch land in the same cycle.
  always_comb begin
    res_alu  = credit_next(AW'(cnt_alu),  AW'(rel_alu),
                           fire ? AW'(need_alu)  : AW'(0), AW'(ALU_LEN));
    res_mem  = credit_next(AW'(cnt_mem),  AW'(rel_mem),
                           fire ? AW'(need_mem)  : AW'(0), AW'(MEM_LEN));
    res_br   = credit_next(AW'(cnt_br),   AW'(rel_br),
                           fire ? AW'(need_br)   : AW'(0), AW'(BR_LEN));
    res_mult = credit_next(AW'(cnt_mult), AW'(rel_mult),
                           fire ? AW'(need_mult) : AW'(0), AW'(MULT_LEN));
    cnt_alu_d  = ALU_CW'(res_alu[AW-1:0]);
    cnt_mem_d  = MEM_CW'(res_mem[AW-1:0]);
    cnt_br_d   = BR_CW'(res_br[AW-1:0]);
    cnt_mult_d = MULT_CW'(res_mult[AW-1:0]);
    err_any    = res_alu[AW] | res_mem[AW] | res_br[AW] | res_mult[AW];
  end

  // Holding register, credit counters and sticky error; flush wins over all.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid  <= 1'b0;
      buf_req    <= '0;
      cnt_alu    <= ALU_CW'(ALU_LEN);
      cnt_mem    <= MEM_CW'(MEM_LEN);
      cnt_br     <= BR_CW'(BR_LEN);
      cnt_mult   <= MULT_CW'(MULT_LEN);
      credit_err <= 1'b0;
    end else if (flush) begin
      buf_valid  <= 1'b0;
      cnt_alu    <= ALU_CW'(ALU_LEN);
      cnt_mem    <= MEM_CW'(MEM_LEN);
      cnt_br     <= BR_CW'(BR_LEN);
      cnt_mult   <= MULT_CW'(MULT_LEN);
    end else begin
      if (accept) begin
        buf_req   <= in_req;
        buf_valid <= 1'b1;
      end else if (fire) begin
        buf_valid <= 1'b0;
      end
      cnt_alu    <= cnt_alu_d;
      cnt_mem    <= cnt_mem_d;
      cnt_br     <= cnt_br_d;
      cnt_mult   <= cnt_mult_d;
      credit_err <= credit_err | err_any;
    end
  end

endmodule

// File: tb/tb_dispatch_stage.sv
// Bench for dispatch_stage: bundles pushed to a scoreboard on acceptance are
// compared against out_req whenever the stage dispatches.
module tb_dispatch_stage;
  import issue_queue_pkg::*;

  typedef write_req_t [WRITE_NUM-1:0] bundle_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  bundle_t    in_req;
  bundle_t    out_req;
  logic       in_ready;
  logic [1:0] rel_alu;
  logic [1:0] rel_mem;
  logic       rel_br;
  logic       rel_mult;
  logic       credit_err;

  int checks   = 0;
  int failures = 0;
  int tag      = 0;

  bundle_t sb[$];
  bundle_t exp_b;

  always #5 clk = ~clk;

  dispatch_stage dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_req     (in_req),
    .in_ready   (in_ready),
    .out_req    (out_req),
    .rel_alu    (rel_alu),
    .rel_mem    (rel_mem),
    .rel_br     (rel_br),
    .rel_mult   (rel_mult),
    .credit_err (credit_err)
  );

  function automatic write_req_t mk(input bit v, input entry_type_e t);
    write_req_t r;
    tag        = tag + 1;
    r          = '0;
    r.valid    = v;
    r.entry_type = t;
    r.rob_idx  = ROB_W'(tag);
    r.pdst     = PREG_W'(tag * 5 + 1);
    r.psrc1    = PREG_W'(tag * 3 + 2);
    r.psrc2    = PREG_W'(tag * 7 + 3);
    r.opcode   = OP_W'(tag * 11 + 4);
    return r;
  endfunction

  function automatic bundle_t mkb(input bit v0, input entry_type_e t0,
                                  input bit v1, input entry_type_e t1);
    bundle_t b;
    b[0] = mk(v0, t0);
    b[1] = mk(v1, t1);
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a bundle until accepted; returns 1 ns after the accepting edge.
  task automatic drive_bundle(input bundle_t b, input bit expect_out);
    bit ok;
    ok     = 1'b0;
    in_req = b;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        if (expect_out) sb.push_back(b);
      end
      step();
    end
    in_req = '0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drive_accept_timeout got=in_ready_low exp=accept_within_20");
    end
  endtask

  // Scoreboard: every dispatch must match the oldest accepted bundle.
  always @(negedge clk) begin
    if (resetn === 1'b1 && (out_req[0].valid === 1'b1 || out_req[1].valid === 1'b1)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_dispatch got=%h exp=none", out_req);
      end else begin
        exp_b = sb.pop_front();
        if (out_req !== exp_b) begin
          failures++;
          $display("FAIL sb_dispatch got=%h exp=%h", out_req, exp_b);
        end
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; in_req = '0;
    rel_alu = '0; rel_mem = '0; rel_br = 1'b0; rel_mult = 1'b0;
    repeat (2) step();
    checks++;
    if (in_ready !== 1'b1 || credit_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=rdy%b err%b exp=rdy1 err0", in_ready, credit_err);
    end
    checks++;
    if (out_req[0].valid !== 1'b0 || out_req[1].valid !== 1'b0 || dut.buf_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b%b buf%b exp=00 buf0",
               out_req[0].valid, out_req[1].valid, dut.buf_valid);
    end
    checks++;
    if ({dut.cnt_alu, dut.cnt_mem, dut.cnt_br, dut.cnt_mult} !== {4'd8, 4'd8, 2'd2, 2'd2}) begin
      failures++;
      $display("FAIL reset_credits got=%0d,%0d,%0d,%0d exp=8,8,2,2",
               dut.cnt_alu, dut.cnt_mem, dut.cnt_br, dut.cnt_mult);
    end
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single_alu();
    in_req = mkb(1'b0, ET_ALU, 1'b0, ET_MEM);
    step();
    in_req = '0;
    checks++;
    if (dut.buf_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_bundle_ignored got=%b exp=0", dut.buf_valid);
    end
    drive_bundle(mkb(1'b1, ET_ALU, 1'b0, ET_MEM), 1'b1);
    @(negedge clk);
    checks++;
    if (out_req[0].valid !== 1'b1 || out_req[1].valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL alu_fire got=v%b%b rdy%b exp=v10 rdy1",
               out_req[0].valid, out_req[1].valid, in_ready);
    end
    step();
    checks++;
    if (dut.cnt_alu !== 4'd7) begin
      failures++;
      $display("FAIL alu_credit got=%0d exp=7", dut.cnt_alu);
    end
  endtask

  task automatic test_back_to_back();
    drive_bundle(mkb(1'b1, ET_BRANCH, 1'b1, ET_BRANCH), 1'b1);
    drive_bundle(mkb(1'b1, ET_BRANCH, 1'b1, ET_BRANCH), 1'b1);
    checks++;
    if (dut.cnt_br !== 2'd0) begin
      failures++;
      $display("FAIL br_first_credit got=%0d exp=0", dut.cnt_br);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_req[0].valid !== 1'b0 || out_req[1].valid !== 1'b0) begin
      failures++;
      $display("FAIL br_stall0 got=rdy%b v%b%b exp=rdy0 v00",
               in_ready, out_req[0].valid, out_req[1].valid);
    end
    rel_br = 1'b1;
    step();
    rel_br = 1'b0;
    checks++;
    if (dut.cnt_br !== 2'd1) begin
      failures++;
      $display("FAIL br_one_release got=%0d exp=1", dut.cnt_br);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_req[0].valid !== 1'b0 || out_req[1].valid !== 1'b0) begin
      failures++;
      $display("FAIL br_stall1 got=rdy%b v%b%b exp=rdy0 v00",
               in_ready, out_req[0].valid, out_req[1].valid);
    end
    rel_br = 1'b1;
    step();
    rel_br = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_req[0].valid !== 1'b1 || out_req[1].valid !== 1'b1) begin
      failures++;
      $display("FAIL br_second_fire got=rdy%b v%b%b exp=rdy1 v11",
               in_ready, out_req[0].valid, out_req[1].valid);
    end
    step();
    checks++;
    if (dut.cnt_br !== 2'd0 || dut.buf_valid !== 1'b0) begin
      failures++;
      $display("FAIL br_end got=cnt%0d buf%b exp=cnt0 buf0", dut.cnt_br, dut.buf_valid);
    end
  endtask

  task automatic test_mixed_mult_alu();
    drive_bundle(mkb(1'b1, ET_MULT, 1'b1, ET_MULT), 1'b1);
    drive_bundle(mkb(1'b1, ET_MULT, 1'b1, ET_ALU), 1'b1);
    checks++;
    if (dut.cnt_mult !== 2'd0 || dut.cnt_alu !== 4'd7) begin
      failures++;
      $display("FAIL mixed_pre got=mult%0d alu%0d exp=mult0 alu7", dut.cnt_mult, dut.cnt_alu);
    end
    @(negedge clk);
    checks++;
    if (out_req[0].valid !== 1'b0 || out_req[1].valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mixed_stall got=v%b%b rdy%b exp=v00 rdy0",
               out_req[0].valid, out_req[1].valid, in_ready);
    end
    rel_mult = 1'b1;
    step();
    rel_mult = 1'b0;
    @(negedge clk);
    checks++;
    if (out_req[0].valid !== 1'b1 || out_req[1].valid !== 1'b1) begin
      failures++;
      $display("FAIL mixed_fire got=v%b%b exp=v11", out_req[0].valid, out_req[1].valid);
    end
    step();
    checks++;
    if (dut.cnt_mult !== 2'd0 || dut.cnt_alu !== 4'd6) begin
      failures++;
      $display("FAIL mixed_credits got=mult%0d alu%0d exp=mult0 alu6", dut.cnt_mult, dut.cnt_alu);
    end
  endtask

  task automatic test_mem_release_and_fire();
    drive_bundle(mkb(1'b1, ET_MEM, 1'b1, ET_MEM), 1'b1);
    drive_bundle(mkb(1'b1, ET_MEM, 1'b1, ET_MEM), 1'b1);
    drive_bundle(mkb(1'b1, ET_MEM, 1'b0, ET_ALU), 1'b1);
    drive_bundle(mkb(1'b1, ET_MEM, 1'b1, ET_MEM), 1'b1);
    checks++;
    if (dut.cnt_mem !== 4'd3) begin
      failures++;
      $display("FAIL mem_pre got=%0d exp=3", dut.cnt_mem);
    end
    rel_mem = 2'd2;
    @(negedge clk);
    checks++;
    if (out_req[0].valid !== 1'b1 || out_req[1].valid !== 1'b1) begin
      failures++;
      $display("FAIL mem_fire got=v%b%b exp=v11", out_req[0].valid, out_req[1].valid);
    end
    step();
    rel_mem = '0;
    checks++;
    if (dut.cnt_mem !== 4'd3 || credit_err !== 1'b0) begin
      failures++;
      $display("FAIL mem_net got=cnt%0d err%b exp=cnt3 err0", dut.cnt_mem, credit_err);
    end
  endtask

  task automatic test_flush();
    drive_bundle(mkb(1'b1, ET_ALU, 1'b1, ET_ALU), 1'b1);
    drive_bundle(mkb(1'b1, ET_ALU, 1'b1, ET_ALU), 1'b1);
    drive_bundle(mkb(1'b1, ET_ALU, 1'b1, ET_ALU), 1'b1);
    drive_bundle(mkb(1'b1, ET_ALU, 1'b1, ET_ALU), 1'b0);
    checks++;
    if (dut.cnt_alu !== 4'd0 || dut.buf_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre got=alu%0d buf%b exp=alu0 buf1", dut.cnt_alu, dut.buf_valid);
    end
    @(negedge clk);
    flush   = 1'b1;
    rel_alu = 2'd2;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_req[0].valid !== 1'b0 || out_req[1].valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_stalled_cycle got=rdy%b v%b%b exp=rdy0 v00",
               in_ready, out_req[0].valid, out_req[1].valid);
    end
    step();
    flush   = 1'b0;
    rel_alu = '0;
    checks++;
    if (dut.buf_valid !== 1'b0 || credit_err !== 1'b0) begin
      failures++;
      $display("FAIL flush_buf got=buf%b err%b exp=buf0 err0", dut.buf_valid, credit_err);
    end
    checks++;
    if ({dut.cnt_alu, dut.cnt_mem, dut.cnt_br, dut.cnt_mult} !== {4'd8, 4'd8, 2'd2, 2'd2}) begin
      failures++;
      $display("FAIL flush_credits got=%0d,%0d,%0d,%0d exp=8,8,2,2",
               dut.cnt_alu, dut.cnt_mem, dut.cnt_br, dut.cnt_mult);
    end
    // Flush in a cycle that would otherwise fire; the new in_req is dropped.
    drive_bundle(mkb(1'b1, ET_ALU, 1'b1, ET_MEM), 1'b0);
    flush  = 1'b1;
    in_req = mkb(1'b1, ET_BRANCH, 1'b0, ET_ALU);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_req[0].valid !== 1'b0 || out_req[1].valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_fire_cycle got=rdy%b v%b%b exp=rdy1 v00",
               in_ready, out_req[0].valid, out_req[1].valid);
    end
    step();
    flush  = 1'b0;
    in_req = '0;
    checks++;
    if (dut.buf_valid !== 1'b0 || dut.cnt_alu !== 4'd8 || dut.cnt_mem !== 4'd8) begin
      failures++;
      $display("FAIL flush_drop got=buf%b alu%0d mem%0d exp=buf0 alu8 mem8",
               dut.buf_valid, dut.cnt_alu, dut.cnt_mem);
    end
    repeat (2) step();
  endtask

  task automatic test_credit_err();
    checks++;
    if (credit_err !== 1'b0) begin
      failures++;
      $display("FAIL err_pre got=%b exp=0", credit_err);
    end
    rel_br = 1'b1;
    step();
    rel_br = 1'b0;
    checks++;
    if (credit_err !== 1'b1 || dut.cnt_br !== 2'd2) begin
      failures++;
      $display("FAIL err_overflow got=err%b br%0d exp=err1 br2", credit_err, dut.cnt_br);
    end
    repeat (3) step();
    checks++;
    if (credit_err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", credit_err);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (credit_err !== 1'b0) begin
      failures++;
      $display("FAIL err_async_reset got=%b exp=0", credit_err);
    end
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_back_to_back();
    test_mixed_mult_alu();
    test_mem_release_and_fire();
    test_flush();
    test_credit_err();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
